mul4x4_arbiter: RTL and testbench
=================================

Name: mul4x4_arbiter

Overview:
- Round-robin scheduler that shares one mul4x4 sequential multiplier between NREQ requesters.
- Latches the winning requester's operands, pulses the multiplier START, waits for DONE, then returns the 8-bit product with a one-hot ACK.
- Sits between client blocks and the single mul4x4 instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 15, WAIT-state cycle limit (used only with MUL_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, synchronous, active-low: sampled on the CLK rising edge, RST=0 resets.
- REQ  in  NREQ  per-requester request level.
- A_IN  in  4*NREQ  operand A; requester i uses bits [4i+3:4i].
- B_IN  in  4*NREQ  operand B; same packing as A_IN.
- ACK  out  NREQ  one-hot, one-cycle pulse: result for requester i valid.
- Y_OUT  out  8  product, valid in the ACK cycle, held until the next capture.
- ERR  out  1  timeout flag, pulses together with ACK.
- BUSY  out  1  high whenever state is not IDLE.
- MUL_START  out  1  to mul4x4 START; one-cycle pulse.
- MUL_A  out  4  to mul4x4 A; latched operand.
- MUL_B  out  4  to mul4x4 B; latched operand.
- MUL_DONE  in  1  from mul4x4 DONE.
- MUL_Y  in  8  from mul4x4 Y.

Behaviour:
- Reset (RST=0 at an edge) clears all of the following, regardless of state:
  - ACK, Y_OUT, ERR, BUSY, MUL_START, MUL_A, MUL_B are all 0.
  - State is IDLE.
  - Priority pointer is cleared, so requester 0 has highest priority first.
- Reset mid-operation aborts the operation with no ACK. The mul4x4 shares the system reset.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If REQ != 0, select the first set bit scanning upward from last_grant+1 (modulo NREQ).
  - Latch that index plus its A/B slice into MUL_A/MUL_B, then go to ISSUE.
  - If REQ = 0, stay in IDLE.
- ISSUE: MUL_START=1 for exactly this cycle; go to WAIT.
- WAIT:
  - On MUL_DONE=1, capture MUL_Y into Y_OUT and go to RESP.
  - MUL_START stays 0 throughout.
- RESP:
  - ACK[idx]=1 for exactly this cycle.
  - last_grant <= idx; go to IDLE.
- Latency, with the mul4x4 taking 4 cycles from START to DONE:
  - REQ sampled at edge 0.
  - MUL_START high in cycle 1.
  - MUL_DONE high in cycle 5.
  - ACK and Y_OUT valid in cycle 6.
- Earliest next MUL_START is cycle 8 (IDLE in cycle 7). Back-to-back service period is 7 cycles.
- Requester contract: hold REQ high and operands stable until ACK.
- REQ deasserted before the latch edge withdraws the request.
- After the latch, REQ and A_IN/B_IN changes are ignored; the operation completes and ACK still pulses.
- REQ still high in the ACK cycle is a new request. Round-robin then serves the other pending requesters first.
- Simultaneous requests: exactly one is granted per pass. No requester waits more than NREQ-1 services while others are pending.
- MUL_DONE while in IDLE, ISSUE or RESP is ignored.
- MUL_A/MUL_B stay stable from ISSUE until the next latch.
- Y_OUT does not change outside the WAIT->RESP capture.
- ERR is 0 except as defined under the optional feature.

Optional Feature:
- Macro: MUL_TIMEOUT_EN.
- Defined:
  - A cycle counter (width clog2(TIMEOUT+1)) clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no MUL_DONE, go to RESP with Y_OUT=0 and ERR=1 alongside ACK[idx].
  - Normal completions give ERR=0.
  - MUL_DONE and timeout in the same cycle: DONE wins, capture MUL_Y, ERR=0.
- Not defined: no counter; WAIT lasts until MUL_DONE indefinitely; ERR is tied to 0.

Test Plan:
- Single request: REQ=0001, A_IN[3:0]=5, B_IN[3:0]=4 -> MUL_START one cycle, then ACK=0001 with Y_OUT=20 in cycle 6; BUSY low in cycle 7; Y_OUT stays 20.
- Simultaneous after reset: REQ=0011 (req0 10*10, req1 3*7) -> ACK=0001/Y_OUT=100 first, then ACK=0010/Y_OUT=21; exactly one MUL_START per service.
- Fairness: REQ=1111 held continuously -> ACK order 0001, 0010, 0100, 1000, 0001, ...; operands 15*15 for all -> every Y_OUT=225.
- Withdrawal and post-latch drop:
  - REQ[2] pulsed while busy serving req0 and dropped before the latch -> no ACK[2].
  - REQ[1] dropped during WAIT -> ACK[1] still pulses with the correct product.
- Reset mid-operation: RST=0 for one edge during WAIT -> next cycle all outputs 0, no ACK; a fresh REQ=0100 (2*3) is then served with Y_OUT=6.
- Timeout (MUL_TIMEOUT_EN, stub multiplier that never asserts DONE) -> ACK pulses with ERR=1 and Y_OUT=0, TIMEOUT+1 cycles after MUL_START; without the macro, BUSY stays high and ERR stays 0.

Source files
------------

// File: rtl/mul4x4_arbiter.sv
// Round-robin scheduler sharing one sequential mul4x4 between NREQ requesters.
// Optional WAIT-state timeout with ERR reporting is enabled by defining MUL_TIMEOUT_EN.
module mul4x4_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     REQ,
    input  logic [4*NREQ-1:0]   A_IN,
    input  logic [4*NREQ-1:0]   B_IN,
    output logic [NREQ-1:0]     ACK,
    output logic [7:0]          Y_OUT,
    output logic                ERR,
    output logic                BUSY,
    output logic                MUL_START,
    output logic [3:0]          MUL_A,
    output logic [3:0]          MUL_B,
    input  logic                MUL_DONE,
    input  logic [7:0]          MUL_Y
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("mul4x4_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   w_pick;
    logic            w_found;
    logic            w_latch;
    logic            w_capture;
    logic            w_expire;
    logic            w_tmo;

    function automatic logic [IW-1:0] rr_slot(input logic [IW-1:0] base, input int unsigned k);
        return IW'((32'(base) + k) % NREQ);
    endfunction

    // First requesting slot after the last grant, wrapping modulo NREQ; the
    // descending scan lets the nearest slot overwrite the farther ones.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            if (REQ[rr_slot(r_last, k)]) begin
                w_pick  = rr_slot(r_last, k);
                w_found = 1'b1;
            end
        end
    end

`ifdef MUL_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    // WAIT-cycle counter; expiry fires on the edge where the count reaches TIMEOUT.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign w_tmo = (r_state == S_WAIT) && (r_cnt == CW'(TIMEOUT - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_capture = 1'b0;
        w_expire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next  = S_ISSUE;
                    w_latch = 1'b1;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                // A DONE arriving in the expiry cycle still wins.
                if (MUL_DONE) begin
                    w_next    = S_RESP;
                    w_capture = 1'b1;
                end else if (w_tmo) begin
                    w_next   = S_RESP;
                    w_expire = 1'b1;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ACK       <= '0;
            Y_OUT     <= '0;
            ERR       <= 1'b0;
            BUSY      <= 1'b0;
            MUL_START <= 1'b0;
            MUL_A     <= '0;
            MUL_B     <= '0;
            r_idx     <= '0;
            r_last    <= IW'(NREQ - 1);
        end else begin
            BUSY      <= (w_next != S_IDLE);
            MUL_START <= (w_next == S_ISSUE);
            ACK       <= (w_next == S_RESP) ? (NREQ'(1) << r_idx) : '0;
            ERR       <= w_expire;
            if (w_latch) begin
                r_idx <= w_pick;
                MUL_A <= A_IN[{w_pick, 2'b00} +: 4];
                MUL_B <= B_IN[{w_pick, 2'b00} +: 4];
            end
            if (w_capture) begin
                Y_OUT <= MUL_Y;
            end else if (w_expire) begin
                Y_OUT <= '0;
            end
            if (r_state == S_RESP) begin
                r_last <= r_idx;
            end
        end
    end

endmodule

// File: tb/tb_mul4x4_arbiter.sv
// Bench for mul4x4_arbiter: behavioural 4-cycle multiplier, vector table,
// directed corner sequences and a randomized run against a round-robin model.
module tb_mul4x4_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;
    localparam int AW      = 4 * NREQ;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [NREQ-1:0] REQ = '0;
    logic [AW-1:0]   A_IN = '0;
    logic [AW-1:0]   B_IN = '0;
    logic [NREQ-1:0] ACK;
    logic [7:0]      Y_OUT;
    logic            ERR;
    logic            BUSY;
    logic            MUL_START;
    logic [3:0]      MUL_A;
    logic [3:0]      MUL_B;
    logic            MUL_DONE;
    logic [7:0]      MUL_Y;

    int n_checks = 0;
    int n_err    = 0;
    int n_start  = 0;

    bit          m_stall = 1'b0;
    bit          m_spur  = 1'b0;
    logic [2:0]  m_cnt   = '0;
    logic [7:0]  m_y     = '0;

    mul4x4_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .A_IN(A_IN), .B_IN(B_IN),
        .ACK(ACK), .Y_OUT(Y_OUT), .ERR(ERR), .BUSY(BUSY),
        .MUL_START(MUL_START), .MUL_A(MUL_A), .MUL_B(MUL_B),
        .MUL_DONE(MUL_DONE), .MUL_Y(MUL_Y)
    );

    always #5 CLK = ~CLK;

    // Multiplier stand-in: DONE four cycles after START, shares the reset.
    always @(posedge CLK) begin
        if (!RST) begin
            m_cnt <= '0;
        end else if (MUL_START) begin
            m_cnt <= 3'd4;
            m_y   <= 8'(MUL_A) * 8'(MUL_B);
        end else if (m_cnt != 3'd0) begin
            m_cnt <= m_cnt - 3'd1;
        end
    end
    assign MUL_DONE = (!m_stall && m_cnt == 3'd1) || m_spur;
    assign MUL_Y    = m_spur ? 8'hA5 : m_y;

    always @(posedge CLK) begin
        if (MUL_START) n_start <= n_start + 1;
    end

    typedef struct {
        int              idx;
        logic [3:0]      a;
        logic [3:0]      b;
        logic [NREQ-1:0] exp_ack;
        logic [7:0]      exp_y;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        REQ     = '0;
        m_stall = 1'b0;
        m_spur  = 1'b0;
        RST     = 1'b0;
        step();
        RST     = 1'b1;
    endtask

    // Advances at least one cycle, stopping on the first ACK or after 40 cycles.
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (ACK == '0 && n < 40);
    endtask

    task automatic do_single(input int idx, input logic [3:0] a, input logic [3:0] b,
                             input logic [NREQ-1:0] exp_ack, input logic [7:0] exp_y);
        int n;
        A_IN = AW'($urandom);
        B_IN = AW'($urandom);
        A_IN[4*idx +: 4] = a;
        B_IN[4*idx +: 4] = b;
        REQ = '0;
        REQ[idx] = 1'b1;
        step();
        check("single_start", 32'(MUL_START), 32'd1);
        check("single_mul_a", 32'(MUL_A), 32'(a));
        check("single_mul_b", 32'(MUL_B), 32'(b));
        wait_ack(n);
        check("single_latency", 32'(n), 32'd5);
        check("single_ack", 32'(ACK), 32'(exp_ack));
        check("single_y", 32'(Y_OUT), 32'(exp_y));
        check("single_err", 32'(ERR), 32'd0);
        REQ = '0;
        step();
        check("single_busy_low", 32'(BUSY), 32'd0);
        check("single_y_hold", 32'(Y_OUT), 32'(exp_y));
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] req, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (((req >> ((last + k) % NREQ)) & NREQ'(1)) != '0) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Random requesters obeying the hold-until-ACK contract, checked against
    // a transaction-level model: grant chosen at the latch, ACK five cycles later.
    task automatic run_random(input int ncyc);
        logic [NREQ-1:0] req_prev;
        logic [AW-1:0]   a_prev;
        logic [AW-1:0]   b_prev;
        logic            busy_prev;
        int              last_g;
        int              exp_g;
        int              exp_y;
        int              age;
        bit              pend;
        last_g = NREQ - 1;
        exp_g  = 0;
        exp_y  = 0;
        age    = 0;
        pend   = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            req_prev  = REQ;
            a_prev    = A_IN;
            b_prev    = B_IN;
            busy_prev = BUSY;
            step();
            if (pend) age++;
            if (pend && age == 5) begin
                check("rnd_ack", 32'(ACK), 32'(1 << exp_g));
                check("rnd_y", 32'(Y_OUT), 32'(exp_y));
                last_g = exp_g;
                pend   = 1'b0;
            end else begin
                check("rnd_no_ack", 32'(ACK), 32'd0);
            end
            if (!busy_prev) begin
                check("rnd_grant", 32'(BUSY), 32'(req_prev != '0));
                if (req_prev != '0) begin
                    exp_g = rr_pick(req_prev, last_g);
                    exp_y = int'(a_prev[4*exp_g +: 4]) * int'(b_prev[4*exp_g +: 4]);
                    pend  = 1'b1;
                    age   = 0;
                    check("rnd_mul_a", 32'(MUL_A), 32'(a_prev[4*exp_g +: 4]));
                    check("rnd_mul_b", 32'(MUL_B), 32'(b_prev[4*exp_g +: 4]));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (REQ[i]) begin
                    if (ACK[i]) begin
                        if ($urandom_range(1, 0) == 0) begin
                            REQ[i] = 1'b0;
                        end else begin
                            A_IN[4*i +: 4] = 4'($urandom);
                            B_IN[4*i +: 4] = 4'($urandom);
                        end
                    end else if (!(pend && exp_g == i) && $urandom_range(7, 0) == 0) begin
                        REQ[i] = 1'b0;
                    end
                end else if ($urandom_range(3, 0) == 0) begin
                    REQ[i] = 1'b1;
                    A_IN[4*i +: 4] = 4'($urandom);
                    B_IN[4*i +: 4] = 4'($urandom);
                end
            end
        end
        REQ = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        int s0;

        vecs[0] = '{0, 4'd5,  4'd4,  4'b0001, 8'd20};
        vecs[1] = '{1, 4'd15, 4'd15, 4'b0010, 8'd225};
        vecs[2] = '{2, 4'd0,  4'd9,  4'b0100, 8'd0};
        vecs[3] = '{3, 4'd1,  4'd1,  4'b1000, 8'd1};
        vecs[4] = '{0, 4'd15, 4'd0,  4'b0001, 8'd0};
        vecs[5] = '{2, 4'd12, 4'd13, 4'b0100, 8'd156};

        do_reset();
        check("rst_ack", 32'(ACK), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_start", 32'(MUL_START), 32'd0);

        for (int v = 0; v < 6; v++) begin
            do_single(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].exp_ack, vecs[v].exp_y);
        end

        // DONE outside WAIT must be ignored
        m_spur = 1'b1;
        step();
        m_spur = 1'b0;
        step();
        check("spur_y", 32'(Y_OUT), 32'(vecs[5].exp_y));
        check("spur_busy", 32'(BUSY), 32'd0);
        check("spur_ack", 32'(ACK), 32'd0);

        // simultaneous requests after reset
        do_reset();
        s0   = n_start;
        A_IN = '0;
        B_IN = '0;
        A_IN[3:0] = 4'd10;
        B_IN[3:0] = 4'd10;
        A_IN[7:4] = 4'd3;
        B_IN[7:4] = 4'd7;
        REQ = 4'b0011;
        wait_ack(n);
        check("sim_ack0", 32'(ACK), 32'b0001);
        check("sim_y0", 32'(Y_OUT), 32'd100);
        REQ = 4'b0010;
        wait_ack(n);
        check("sim_ack1", 32'(ACK), 32'b0010);
        check("sim_y1", 32'(Y_OUT), 32'd21);
        check("sim_period", 32'(n), 32'd7);
        REQ = '0;
        step();
        check("sim_starts", 32'(n_start - s0), 32'd2);

        // fairness with all requesters held
        do_reset();
        A_IN = '1;
        B_IN = '1;
        REQ  = '1;
        for (int k = 0; k < 8; k++) begin
            wait_ack(n);
            check("rr_ack", 32'(ACK), 32'(1 << (k % NREQ)));
            check("rr_y", 32'(Y_OUT), 32'd225);
            if (k > 0) check("rr_period", 32'(n), 32'd7);
        end
        REQ = '0;
        step();

        // withdrawal before latch, then drop after latch
        do_reset();
        A_IN = '0;
        B_IN = '0;
        A_IN[3:0] = 4'd3;
        B_IN[3:0] = 4'd3;
        REQ = 4'b0001;
        step();
        step();
        REQ[2] = 1'b1;
        A_IN[11:8] = 4'd9;
        B_IN[11:8] = 4'd9;
        step();
        REQ[2] = 1'b0;
        wait_ack(n);
        check("wd_ack", 32'(ACK), 32'b0001);
        check("wd_y", 32'(Y_OUT), 32'd9);
        REQ = '0;
        bad = 0;
        repeat (12) begin
            step();
            if (ACK != '0 || BUSY) bad = 1;
        end
        check("wd_no_service", 32'(bad), 32'd0);

        A_IN[7:4] = 4'd6;
        B_IN[7:4] = 4'd7;
        REQ = 4'b0010;
        step();
        check("drop_start", 32'(MUL_START), 32'd1);
        step();
        REQ = '0;
        A_IN[7:4] = 4'd1;
        B_IN[7:4] = 4'd1;
        wait_ack(n);
        check("drop_ack", 32'(ACK), 32'b0010);
        check("drop_y", 32'(Y_OUT), 32'd42);
        check("drop_latency", 32'(n), 32'd4);
        check("drop_mul_a", 32'(MUL_A), 32'd6);
        step();

        // reset while waiting for the multiplier
        A_IN[3:0] = 4'd5;
        B_IN[3:0] = 4'd5;
        REQ = 4'b0001;
        step();
        step();
        step();
        check("rmid_busy", 32'(BUSY), 32'd1);
        RST = 1'b0;
        REQ = '0;
        step();
        RST = 1'b1;
        check("rmid_ack", 32'(ACK), 32'd0);
        check("rmid_y", 32'(Y_OUT), 32'd0);
        check("rmid_err", 32'(ERR), 32'd0);
        check("rmid_busy0", 32'(BUSY), 32'd0);
        check("rmid_start", 32'(MUL_START), 32'd0);
        check("rmid_mul_a", 32'(MUL_A), 32'd0);
        check("rmid_mul_b", 32'(MUL_B), 32'd0);
        bad = 0;
        repeat (10) begin
            step();
            if (ACK != '0 || BUSY) bad = 1;
        end
        check("rmid_no_ack", 32'(bad), 32'd0);
        do_single(2, 4'd2, 4'd3, 4'b0100, 8'd6);

        // multiplier that never finishes
        do_reset();
        m_stall = 1'b1;
        A_IN[3:0] = 4'd3;
        B_IN[3:0] = 4'd5;
        REQ = 4'b0001;
        step();
        check("stall_start", 32'(MUL_START), 32'd1);
`ifdef MUL_TIMEOUT_EN
        wait_ack(n);
        check("tmo_latency", 32'(n), 32'(TIMEOUT + 1));
        check("tmo_ack", 32'(ACK), 32'b0001);
        check("tmo_err", 32'(ERR), 32'd1);
        check("tmo_y", 32'(Y_OUT), 32'd0);
        REQ = '0;
        step();
        check("tmo_err_clear", 32'(ERR), 32'd0);
        check("tmo_busy_low", 32'(BUSY), 32'd0);
`else
        bad = 0;
        repeat (40) begin
            step();
            if (!BUSY || ERR || ACK != '0) bad = 1;
        end
        check("stall_held", 32'(bad), 32'd0);
`endif

        do_reset();
        run_random(600);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
